// File: rtl/branch_pkg.sv
// Shared definitions for the branch predictor: branch/compare encodings,
// 2-bit counter states, FSM states and the branch outcome decoder.
package branch_pkg;

  localparam logic [2:0] BR_BEQ = 3'b001;
  localparam logic [2:0] BR_BNE = 3'b010;
  localparam logic [2:0] BR_BGE = 3'b011;
  localparam logic [2:0] BR_BGT = 3'b100;

  localparam logic [1:0] CMP_LT = 2'b00;
  localparam logic [1:0] CMP_EQ = 2'b01;
  localparam logic [1:0] CMP_GT = 2'b10;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_REDIRECT = 2'b01,
    ST_DRAIN    = 2'b10
  } fsm_state_e;

  typedef struct packed {
    logic is_branch;
    logic taken;
  } outcome_t;

  // Decode branch code and compare status. cmp==11 matches no taken
  // condition, so it resolves as not-taken for every code.
  function automatic outcome_t branch_outcome(input logic [2:0] br,
                                              input logic [1:0] cmp);
    outcome_t o;
    o = '{is_branch: 1'b1, taken: 1'b0};
    case (br)
      BR_BEQ:  o.taken = (cmp == CMP_EQ);
      BR_BNE:  o.taken = (cmp == CMP_GT) || (cmp == CMP_LT);
      BR_BGE:  o.taken = (cmp == CMP_EQ) || (cmp == CMP_GT);
      BR_BGT:  o.taken = (cmp == CMP_GT);
      default: o.is_branch = 1'b0;
    endcase
    return o;
  endfunction

  // Saturating 2-bit counter step.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr,
                                          input logic       taken);
    logic [1:0] n;
    n = ctr;
    if (taken && ctr != CTR_ST)       n = ctr + 2'd1;
    else if (!taken && ctr != CTR_SNT) n = ctr - 2'd1;
    return n;
  endfunction

endpackage

// File: rtl/branch_predict_ctrl_if.sv
// Fetch lookup, EX resolution and redirect/statistics signals between the
// pipeline (master) and the branch predictor (slave).
interface branch_predict_ctrl_if #(
  parameter int PC_W = 32
);
  logic [PC_W-1:0] if_pc_i;
  logic            pred_taken_o;
  logic            res_valid_i;
  logic [PC_W-1:0] res_pc_i;
  logic [2:0]      res_branch_i;
  logic [1:0]      res_cmp_i;
  logic            res_pred_i;
  logic [PC_W-1:0] res_target_i;
  logic            redirect_o;
  logic [PC_W-1:0] redirect_pc_o;
  logic            flush_o;
  logic [15:0]     br_cnt_o;
  logic [15:0]     mis_cnt_o;

  modport master (
    output if_pc_i, res_valid_i, res_pc_i, res_branch_i, res_cmp_i,
           res_pred_i, res_target_i,
    input  pred_taken_o, redirect_o, redirect_pc_o, flush_o,
           br_cnt_o, mis_cnt_o
  );

  modport slave (
    input  if_pc_i, res_valid_i, res_pc_i, res_branch_i, res_cmp_i,
           res_pred_i, res_target_i,
    output pred_taken_o, redirect_o, redirect_pc_o, flush_o,
           br_cnt_o, mis_cnt_o
  );
endinterface

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters: one asynchronous
// read port (taken bit only) and one synchronous update port.
module bht_2bit
  import branch_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_taken_o,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  localparam int DEPTH = 1 << IDX_W;

  logic [1:0] ctr_q [DEPTH];

  // Lookup reads the stored counter; a same-cycle update is not bypassed.
  assign rd_taken_o = ctr_q[rd_idx_i][1];

  // Counter table: weak-NT after reset, saturating step on each update.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: every entry is reset (not just the state machine) because a
      // prediction is read from any entry on the very first fetch after reset.
      for (int i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_WNT;
    end else if (upd_en_i) begin
      ctr_q[upd_idx_i] <= ctr_next(ctr_q[upd_idx_i], upd_taken_i);
    end
  end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Dynamic branch predictor with mispredict redirect/flush sequencing and
// saturating branch/mispredict statistics.
module branch_predict_ctrl
  import branch_pkg::*;
#(
  parameter int IDX_W     = 4,
  parameter int PC_W      = 32,
  parameter int FLUSH_CYC = 2
) (
  input logic                clk_i,
  input logic                rst_i,
  branch_predict_ctrl_if.slave bus
);

  localparam int CNT_W = (FLUSH_CYC > 2) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD =
    CNT_W'((FLUSH_CYC > 1) ? FLUSH_CYC - 2 : 0);

  fsm_state_e      state_q, state_d;
  logic [CNT_W-1:0] drain_q, drain_d;
  logic [PC_W-1:0] redirect_pc_q;
  logic [15:0]     br_cnt_q;
  logic [15:0]     mis_cnt_q;

  outcome_t        res_out;
  logic            accept;
  logic            mispredict;
  logic [PC_W-1:0] correct_pc;
  logic            unused_if_pc;

  assign unused_if_pc = ^bus.if_pc_i;

  bht_2bit #(.IDX_W(IDX_W)) u_bht (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rd_idx_i    (bus.if_pc_i[IDX_W+1:2]),
    .rd_taken_o  (bus.pred_taken_o),
    .upd_en_i    (accept),
    .upd_idx_i   (bus.res_pc_i[IDX_W+1:2]),
    .upd_taken_i (res_out.taken)
  );

  // Decode the resolving instruction; wrong-path resolutions are dropped.
  always_comb begin
    res_out    = branch_outcome(bus.res_branch_i, bus.res_cmp_i);
    accept     = bus.res_valid_i && res_out.is_branch && (state_q == ST_IDLE);
    mispredict = accept && (res_out.taken != bus.res_pred_i);
    correct_pc = res_out.taken ? bus.res_target_i
                               : bus.res_pc_i + PC_W'(4);
  end

  // Recovery FSM: one REDIRECT cycle, then FLUSH_CYC-1 DRAIN cycles.
  always_comb begin
    // NOTE: next-state defaults to hold so no path leaves state_d/drain_d
    // unassigned, which would infer latches.
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE: begin
        if (mispredict) state_d = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        if (FLUSH_CYC == 1) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) state_d = ST_IDLE;
        else               drain_d = drain_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, latched redirect target and saturating statistics.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      drain_q       <= '0;
      redirect_pc_q <= '0;
      br_cnt_q      <= '0;
      mis_cnt_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register here sample the
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      drain_q <= drain_d;
      if (mispredict) redirect_pc_q <= correct_pc;
      if (accept && br_cnt_q != 16'hFFFF)      br_cnt_q  <= br_cnt_q + 16'd1;
      if (mispredict && mis_cnt_q != 16'hFFFF) mis_cnt_q <= mis_cnt_q + 16'd1;
    end
  end

  assign bus.redirect_o    = (state_q == ST_REDIRECT);
  assign bus.flush_o       = (state_q != ST_IDLE);
  assign bus.redirect_pc_o = redirect_pc_q;
  assign bus.br_cnt_o      = br_cnt_q;
  assign bus.mis_cnt_o     = mis_cnt_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl with a redirect scoreboard.
module tb_branch_predict_ctrl;
  import branch_pkg::*;

  localparam int FLUSH_CYC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   flush_run = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  branch_predict_ctrl_if #(.PC_W(32)) bus ();

  branch_predict_ctrl #(.IDX_W(4), .PC_W(32), .FLUSH_CYC(FLUSH_CYC)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pop the expected target whenever a redirect is presented and
  // check each flush burst length once it ends.
  always @(negedge clk) begin
    if (rst) begin
      flush_run = 0;
    end else begin
      if (bus.redirect_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_redirect", 32'd1, 32'd0);
        end else begin
          check("redirect_pc", bus.redirect_pc_o, exp_q.pop_front());
          check("flush_with_redirect", {31'd0, bus.flush_o}, 32'd1);
        end
      end
      if (bus.flush_o) begin
        flush_run++;
      end else if (flush_run != 0) begin
        check("flush_len", flush_run, FLUSH_CYC);
        flush_run = 0;
      end
    end
  end

  task automatic drive_res(input logic [31:0] pc, input logic [2:0] br,
                           input logic [1:0] cmp, input logic pred,
                           input logic [31:0] tgt);
    bus.res_valid_i  = 1'b1;
    bus.res_pc_i     = pc;
    bus.res_branch_i = br;
    bus.res_cmp_i    = cmp;
    bus.res_pred_i   = pred;
    bus.res_target_i = tgt;
  endtask

  // One resolution held across exactly one rising edge.
  task automatic resolve(input logic [31:0] pc, input logic [2:0] br,
                         input logic [1:0] cmp, input logic pred,
                         input logic [31:0] tgt);
    drive_res(pc, br, cmp, pred, tgt);
    @(posedge clk);
    #1;
    bus.res_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_pred(input string name, input logic [31:0] pc,
                            input logic exp);
    bus.if_pc_i = pc;
    #1;
    check(name, {31'd0, bus.pred_taken_o}, {31'd0, exp});
  endtask

  task automatic check_cnts(input string name, input logic [15:0] br,
                            input logic [15:0] mis);
    check({name, "_br"},  {16'd0, bus.br_cnt_o},  {16'd0, br});
    check({name, "_mis"}, {16'd0, bus.mis_cnt_o}, {16'd0, mis});
  endtask

  initial begin
    bus.if_pc_i      = '0;
    bus.res_valid_i  = 1'b0;
    bus.res_pc_i     = '0;
    bus.res_branch_i = '0;
    bus.res_cmp_i    = '0;
    bus.res_pred_i   = 1'b0;
    bus.res_target_i = '0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    check("rst_redirect", {31'd0, bus.redirect_o}, 32'd0);
    check("rst_flush", {31'd0, bus.flush_o}, 32'd0);
    check("rst_redirect_pc", bus.redirect_pc_o, 32'd0);
    check_cnts("rst", 16'd0, 16'd0);
    check_pred("rst_pred_40", 32'h40, 1'b0);
    check_pred("rst_pred_fffffffc", 32'hFFFF_FFFC, 1'b0);

    // beq taken at 0x40 predicted NT: redirect to 0x80, counter 01->10
    exp_q.push_back(32'h80);
    drive_res(32'h40, BR_BEQ, CMP_EQ, 1'b0, 32'h80);
    bus.if_pc_i = 32'h40;
    #1;
    check("no_bypass_40", {31'd0, bus.pred_taken_o}, 32'd0);
    @(posedge clk);
    #1;
    bus.res_valid_i = 1'b0;
    check("pred_40_after_taken", {31'd0, bus.pred_taken_o}, 32'd1);
    idle(FLUSH_CYC);
    check_cnts("beq_mis", 16'd1, 16'd1);
    check("redirect_pc_hold", bus.redirect_pc_o, 32'h80);
    // counter 10 -> 01 proves it was weak-T, not strong-T
    resolve(32'h40, BR_BEQ, CMP_LT, 1'b0, 32'h80);
    check_pred("pred_40_back_wnt", 32'h40, 1'b0);

    // bgt not-taken at top of memory predicted T: fall-through wraps to 0
    exp_q.push_back(32'h0);
    resolve(32'hFFFF_FFFC, BR_BGT, CMP_LT, 1'b1, 32'h1234);
    idle(FLUSH_CYC);
    check_cnts("bgt_wrap", 16'd3, 16'd2);
    check_pred("pred_fffc_dec", 32'hFFFF_FFFC, 1'b0);
    // 00 -> 01 keeps predicting NT (01 -> 10 would not)
    resolve(32'hFFFF_FFFC, BR_BGT, CMP_GT, 1'b1, 32'h1234);
    check_pred("pred_fffc_after_inc", 32'hFFFF_FFFC, 1'b0);

    // bne taken x4 at 0x44 saturates at 11, then two not-taken -> 01
    resolve(32'h44, BR_BNE, CMP_GT, 1'b1, 32'h200);
    resolve(32'h44, BR_BNE, CMP_LT, 1'b1, 32'h200);
    resolve(32'h44, BR_BNE, CMP_GT, 1'b1, 32'h200);
    resolve(32'h44, BR_BNE, CMP_LT, 1'b1, 32'h200);
    check_pred("pred_44_sat", 32'h44, 1'b1);
    resolve(32'h44, BR_BNE, CMP_EQ, 1'b0, 32'h200);
    check_pred("pred_44_wt", 32'h44, 1'b1);
    resolve(32'h44, BR_BNE, 2'b11, 1'b0, 32'h200);
    check_pred("pred_44_wnt", 32'h44, 1'b0);
    check_cnts("bne_sat", 16'd10, 16'd2);

    // Mispredict, then two wrong-path beqs (ignored), third accepted
    exp_q.push_back(32'h4C);
    resolve(32'h48, BR_BEQ, CMP_LT, 1'b1, 32'h300);
    resolve(32'h48, BR_BEQ, CMP_EQ, 1'b0, 32'h300);
    resolve(32'h48, BR_BEQ, CMP_EQ, 1'b0, 32'h300);
    resolve(32'h48, BR_BEQ, CMP_LT, 1'b0, 32'h300);
    check_cnts("wrong_path", 16'd12, 16'd3);
    resolve(32'h48, BR_BEQ, CMP_EQ, 1'b1, 32'h300);
    check_pred("pred_48_no_leak", 32'h48, 1'b0);
    check_cnts("after_wrong_path", 16'd13, 16'd3);

    // Non-branch codes: no count, no table write, no redirect
    resolve(32'h4C, 3'b000, CMP_EQ, 1'b0, 32'h400);
    resolve(32'h4C, 3'b111, CMP_EQ, 1'b0, 32'h400);
    resolve(32'h4C, 3'b101, CMP_GT, 1'b0, 32'h400);
    resolve(32'h4C, 3'b110, CMP_LT, 1'b1, 32'h400);
    check_pred("pred_4c_nonbranch", 32'h4C, 1'b0);
    check_cnts("nonbranch", 16'd13, 16'd3);

    // Reset asserted during DRAIN aborts the flush immediately
    exp_q.push_back(32'h80);
    resolve(32'h40, BR_BEQ, CMP_EQ, 1'b0, 32'h80);
    @(posedge clk);
    #1;
    check("flush_in_drain", {31'd0, bus.flush_o}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_drain_flush", {31'd0, bus.flush_o}, 32'd0);
    check("rst_drain_redirect", {31'd0, bus.redirect_o}, 32'd0);
    check("rst_drain_pc", bus.redirect_pc_o, 32'd0);
    check_cnts("rst_drain", 16'd0, 16'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    check_pred("pred_40_after_rst", 32'h40, 1'b0);
    // FSM must be IDLE: a resolution right away is accepted
    resolve(32'h50, BR_BEQ, CMP_LT, 1'b0, 32'h500);
    check_cnts("post_rst_accept", 16'd1, 16'd0);

    // 70000 further correctly-predicted branches saturate br_cnt_o
    drive_res(32'h50, BR_BEQ, CMP_LT, 1'b0, 32'h500);
    repeat (70000) @(posedge clk);
    #1;
    bus.res_valid_i = 1'b0;
    check_cnts("br_sat", 16'hFFFF, 16'd0);
    check("flush_after_sat", {31'd0, bus.flush_o}, 32'd0);

    idle(2);
    check("sb_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
